// File: rtl/iter_div.sv
// Multi-cycle restoring divider: signed/unsigned, one quotient bit per cycle,
// with divide-by-zero detection, annul from any state and operand capture at start.
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               annul,
    output logic               busy,
    output logic               ready,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               armed_q, armed_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               div_zero_q, div_zero_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               accept;
    logic               divisor_zero;
    logic               dvd_neg;
    logic               dvs_neg;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_final;
    logic [WIDTH-1:0]   rem_final;

    // armed_q blocks a restart until start has been seen low while idle
    assign accept       = (state_q == IDLE) && start && !annul && armed_q;
    assign divisor_zero = (divisor == '0);
    assign dvd_neg      = signed_div & dividend[WIDTH-1];
    assign dvs_neg      = signed_div & divisor[WIDTH-1];

    // One restoring step; the WIDTH+1-bit difference carries its own sign
    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvsr_q};
    assign rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    assign quo_final = neg_quo_q ? -quo_next : quo_next;
    assign rem_final = neg_rem_q ? -rem_next : rem_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            armed_q    <= armed_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && armed_q) begin
                        state_d = divisor_zero ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (count_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d    = count_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        armed_d    = armed_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        busy_d     = (state_d == BUSY);
        ready_d    = (state_d == DONE);

        if ((state_q == IDLE) && !start) begin
            armed_d = 1'b1;
        end

        if (accept) begin
            armed_d   = 1'b0;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            if (divisor_zero) begin
                div_zero_d = 1'b1;
                result_d   = {dividend, {WIDTH{1'b1}}};
            end else begin
                div_zero_d = 1'b0;
                quo_d      = dvd_neg ? -dividend : dividend;
                dvsr_d     = dvs_neg ? -divisor : divisor;
                rem_d      = '0;
                count_d    = CNT_INIT;
            end
        end else if ((state_q == BUSY) && !annul) begin
            rem_d   = rem_next;
            quo_d   = quo_next;
            count_d = count_q - CNT_LAST;
            if (count_q == CNT_LAST) begin
                result_d = {rem_final, quo_final};
            end
        end
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign div_zero = div_zero_q;
    assign result   = result_q;

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: a 32-bit and an 8-bit instance sharing
// clock and reset, with a scoreboard queue of expected results per instance.
module tb_iter_div;

    logic        clk;
    logic        resetn;

    logic        start32, sdiv32, annul32;
    logic [31:0] dvd32, dvs32;
    logic        busy32, ready32, dz32;
    logic [63:0] res32;

    logic        start8, sdiv8, annul8;
    logic [7:0]  dvd8, dvs8;
    logic        busy8, ready8, dz8;
    logic [15:0] res8;

    int checks;
    int errors;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp32_t;

    typedef struct {
        logic [15:0] res;
        logic        dz;
        int          lat;
    } exp8_t;

    exp32_t sb32[$];
    exp8_t  sb8[$];

    iter_div #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .start(start32), .signed_div(sdiv32),
        .dividend(dvd32), .divisor(dvs32), .annul(annul32),
        .busy(busy32), .ready(ready32), .div_zero(dz32), .result(res32)
    );

    iter_div #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .signed_div(sdiv8),
        .dividend(dvd8), .divisor(dvs8), .annul(annul8),
        .busy(busy8), .ready(ready8), .div_zero(dz8), .result(res8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: truncating division, remainder takes the dividend's sign
    function automatic logic [63:0] model32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Drives one request with start held until ready; operands are scrambled after acceptance
    task automatic go32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output logic dz, output int lat,
                        output int bcnt, output logic both, output logic tmo);
        sdiv32  = sgn;
        dvd32   = a;
        dvs32   = b;
        start32 = 1'b1;
        lat     = 0;
        bcnt    = 0;
        both    = 1'b0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                dvd32  = $urandom;
                dvs32  = $urandom;
                sdiv32 = ~sgn;
            end
            if (busy32) bcnt++;
            if (busy32 && ready32) both = 1'b1;
        end while (!ready32 && lat < 200);
        tmo = !ready32;
        res = res32;
        dz  = dz32;
    endtask

    task automatic go8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] res, output logic dz, output int lat, output logic tmo);
        sdiv8  = sgn;
        dvd8   = a;
        dvs8   = b;
        start8 = 1'b1;
        lat    = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                dvd8  = 8'($urandom);
                dvs8  = 8'($urandom);
                sdiv8 = ~sgn;
            end
        end while (!ready8 && lat < 100);
        tmo = !ready8;
        res = res8;
        dz  = dz8;
    endtask

    task automatic idle32();
        start32 = 1'b0;
        tick();
        tick();
    endtask

    task automatic idle8();
        start8 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (busy32 !== 1'b0 || ready32 !== 1'b0 || dz32 !== 1'b0 || res32 !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset32: busy=%b ready=%b dz=%b result=%h, need all zero", busy32, ready32, dz32, res32);
        end
        checks++;
        if (busy8 !== 1'b0 || ready8 !== 1'b0 || dz8 !== 1'b0 || res8 !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset8: busy=%b ready=%b dz=%b result=%h, need all zero", busy8, ready8, dz8, res8);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        logic        dz, both, tmo;
        int          lat, bc;
        exp32_t      e;
        e.res = {32'h0000_0002, 32'h0000_000E};
        e.dz  = 1'b0;
        e.lat = 33;
        sb32.push_back(e);
        go32(1'b0, 32'd100, 32'd7, res, dz, lat, bc, both, tmo);
        e = sb32.pop_front();
        checks++;
        if (tmo || lat != e.lat) begin
            errors++;
            $display("[TB] FAIL unsigned_latency: got %0d edges (timeout=%b), need %0d", lat, tmo, e.lat);
        end
        checks++;
        if (res !== e.res || dz !== e.dz) begin
            errors++;
            $display("[TB] FAIL unsigned_result: got %h dz=%b, need %h dz=%b", res, dz, e.res, e.dz);
        end
        checks++;
        if (bc != 32 || both) begin
            errors++;
            $display("[TB] FAIL unsigned_busy: busy cycles %0d overlap=%b, need 32 and no overlap", bc, both);
        end
        idle32();
    endtask

    task automatic test_signed();
        logic [31:0] ta[3];
        logic [31:0] tb[3];
        logic [63:0] tr[3];
        logic [63:0] res;
        logic        dz, both, tmo;
        int          lat, bc;
        exp32_t      e;
        ta = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
        tb = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        tr = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0000_0001, 32'hFFFF_FFFD}, {32'h0, 32'h8000_0000}};
        for (int i = 0; i < 3; i++) begin
            e.res = tr[i];
            e.dz  = 1'b0;
            e.lat = 33;
            sb32.push_back(e);
            go32(1'b1, ta[i], tb[i], res, dz, lat, bc, both, tmo);
            e = sb32.pop_front();
            checks++;
            if (tmo || lat != e.lat || res !== e.res || dz !== e.dz) begin
                errors++;
                $display("[TB] FAIL signed_%0d: got %h dz=%b lat=%0d, need %h dz=%b lat=%0d",
                         i, res, dz, lat, e.res, e.dz, e.lat);
            end
            idle32();
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        logic        dz, both, tmo;
        int          lat, bc;
        exp32_t      e;
        e.res = {32'h1234_5678, 32'hFFFF_FFFF};
        e.dz  = 1'b1;
        e.lat = 1;
        sb32.push_back(e);
        go32(1'b0, 32'h1234_5678, 32'd0, res, dz, lat, bc, both, tmo);
        e = sb32.pop_front();
        checks++;
        if (tmo || lat != e.lat) begin
            errors++;
            $display("[TB] FAIL divzero_latency: got %0d edges, need %0d", lat, e.lat);
        end
        checks++;
        if (res !== e.res || dz !== e.dz) begin
            errors++;
            $display("[TB] FAIL divzero_result: got %h dz=%b, need %h dz=%b", res, dz, e.res, e.dz);
        end
        checks++;
        if (bc != 0) begin
            errors++;
            $display("[TB] FAIL divzero_busy: busy seen %0d cycles, need 0", bc);
        end
        idle32();
    endtask

    task automatic test_annul();
        logic [63:0] res;
        logic        dz, both, tmo;
        int          lat, bc, seen;
        exp32_t      e;
        sdiv32  = 1'b0;
        dvd32   = 32'hDEAD_BEEF;
        dvs32   = 32'd5;
        start32 = 1'b1;
        repeat (10) tick();
        checks++;
        if (busy32 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL annul_pre_busy: busy=%b, need 1", busy32);
        end
        annul32 = 1'b1;
        tick();
        annul32 = 1'b0;
        checks++;
        if (busy32 !== 1'b0 || ready32 !== 1'b0 || res32 !== {32'h1234_5678, 32'hFFFF_FFFF}) begin
            errors++;
            $display("[TB] FAIL annul_idle: busy=%b ready=%b result=%h, need 0 0 %h",
                     busy32, ready32, res32, {32'h1234_5678, 32'hFFFF_FFFF});
        end
        seen = 0;
        repeat (40) begin
            tick();
            if (ready32 || busy32) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL annul_no_restart: busy/ready high for %0d cycles, need 0", seen);
        end
        start32 = 1'b0;
        tick();
        e.res = {32'h0000_000F, 32'h0FFF_FFFF};
        e.dz  = 1'b0;
        e.lat = 33;
        sb32.push_back(e);
        go32(1'b0, 32'hFFFF_FFFF, 32'h10, res, dz, lat, bc, both, tmo);
        e = sb32.pop_front();
        checks++;
        if (tmo || lat != e.lat || res !== e.res || dz !== e.dz) begin
            errors++;
            $display("[TB] FAIL annul_restart: got %h dz=%b lat=%0d, need %h dz=%b lat=%0d",
                     res, dz, lat, e.res, e.dz, e.lat);
        end
        idle32();
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        logic        dz, both, tmo;
        int          lat, bc;
        exp32_t      e;
        sdiv32  = 1'b0;
        dvd32   = 32'd1000;
        dvs32   = 32'd7;
        start32 = 1'b1;
        repeat (5) tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (busy32 !== 1'b0 || ready32 !== 1'b0 || dz32 !== 1'b0 || res32 !== 64'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: busy=%b ready=%b dz=%b result=%h, need all zero", busy32, ready32, dz32, res32);
        end
        start32 = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
        tick();
        e.res = {32'd0, 32'd3};
        e.dz  = 1'b0;
        e.lat = 33;
        sb32.push_back(e);
        go32(1'b0, 32'd9, 32'd3, res, dz, lat, bc, both, tmo);
        e = sb32.pop_front();
        checks++;
        if (tmo || lat != e.lat || res !== e.res || dz !== e.dz) begin
            errors++;
            $display("[TB] FAIL post_reset_op: got %h dz=%b lat=%0d, need %h dz=%b lat=%0d",
                     res, dz, lat, e.res, e.dz, e.lat);
        end
        idle32();
    endtask

    task automatic test_width8();
        logic [15:0] res;
        logic        dz, tmo;
        int          lat, bad;
        exp8_t       e;
        e.res = {8'd2, 8'd66};
        e.dz  = 1'b0;
        e.lat = 9;
        sb8.push_back(e);
        go8(1'b0, 8'd200, 8'd3, res, dz, lat, tmo);
        e = sb8.pop_front();
        checks++;
        if (tmo || lat != e.lat || res !== e.res || dz !== e.dz) begin
            errors++;
            $display("[TB] FAIL w8_unsigned: got %h dz=%b lat=%0d, need %h dz=%b lat=%0d",
                     res, dz, lat, e.res, e.dz, e.lat);
        end
        bad = 0;
        repeat (20) begin
            tick();
            if (ready8 !== 1'b1 || busy8 !== 1'b0 || res8 !== e.res) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL w8_hold_done: %0d cycles left DONE or changed result, need 0", bad);
        end
        idle8();
        e.res = {8'hFE, 8'hEE};
        e.dz  = 1'b0;
        e.lat = 9;
        sb8.push_back(e);
        go8(1'b1, 8'hC8, 8'd3, res, dz, lat, tmo);
        e = sb8.pop_front();
        checks++;
        if (tmo || lat != e.lat || res !== e.res || dz !== e.dz) begin
            errors++;
            $display("[TB] FAIL w8_signed: got %h dz=%b lat=%0d, need %h dz=%b lat=%0d",
                     res, dz, lat, e.res, e.dz, e.lat);
        end
        idle8();
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        logic        dz, both, tmo, sgn;
        logic [31:0] a, b;
        int          lat, bc;
        exp32_t      e;
        for (int i = 0; i < 12; i++) begin
            sgn = (i >= 6);
            a   = $urandom;
            b   = (i % 4 == 3) ? ($urandom >> 20) : $urandom >> (i * 2);
            e.res = model32(sgn, a, b);
            e.dz  = (b == 32'd0);
            e.lat = (b == 32'd0) ? 1 : 33;
            sb32.push_back(e);
            go32(sgn, a, b, res, dz, lat, bc, both, tmo);
            e = sb32.pop_front();
            checks++;
            if (tmo || lat != e.lat || res !== e.res || dz !== e.dz || both) begin
                errors++;
                $display("[TB] FAIL b2b_%0d (%0s %h/%h): got %h dz=%b lat=%0d, need %h dz=%b lat=%0d",
                         i, sgn ? "s" : "u", a, b, res, dz, lat, e.res, e.dz, e.lat);
            end
            idle32();
        end
    endtask

    initial begin
        clk     = 1'b0;
        resetn  = 1'b0;
        checks  = 0;
        errors  = 0;
        start32 = 1'b0;
        sdiv32  = 1'b0;
        annul32 = 1'b0;
        dvd32   = '0;
        dvs32   = '0;
        start8  = 1'b0;
        sdiv8   = 1'b0;
        annul8  = 1'b0;
        dvd8    = '0;
        dvs8    = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_async_reset();
        test_width8();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_div.md
# iter_div

Parametrised multi-cycle restoring divider for the EX stage, the successor to the fixed 32-bit divider. It takes a dividend and a divisor of configurable width in signed or unsigned mode and produces the quotient and remainder one bit per cycle. Compared with the fixed divider it adds an explicit busy flag, divide-by-zero detection with a defined result, annul from any state, and operand capture at start. EX drives `start` and holds its pipeline stall while `ready` is low; it writes HI/LO from `result` when `ready` is high.

## Interface
- `WIDTH`, default 32: operand width; WIDTH ≥ 2, no power-of-two requirement.
- `clk` in 1: clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request; held high by EX until `ready` is seen.
- `signed_div` in 1: 1 = two's-complement operands; sampled with `start`.
- `dividend` in WIDTH: sampled only on the accepting edge.
- `divisor` in WIDTH: sampled only on the accepting edge.
- `annul` in 1: abort the current or pending operation; has priority over `start`.
- `busy` out 1: high while in BUSY.
- `ready` out 1: high while in DONE; `result` is valid.
- `div_zero` out 1: valid with `ready`; 1 = divisor was zero.
- `result` out 2*WIDTH: {remainder, quotient}; remainder in the upper WIDTH bits.

## Operation
- States: IDLE, BUSY, DONE. Iteration counter width is `$clog2(WIDTH+1)`.
- **IDLE**
  - `start` high and `annul` low: latch `signed_div` and the operand sign bits.
  - Divisor zero: go to DONE. `result` = {dividend, all-ones}, `div_zero` = 1.
  - Divisor non-zero: latch the absolute values of both operands (absolute value only when `signed_div` = 1), clear the partial remainder, set counter = WIDTH, go to BUSY.
- **BUSY**
  - Each cycle: shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude using a (WIDTH+1)-bit subtract.
  - If the difference is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - Decrement the counter.
  - On the iteration where counter = 1: register the sign-corrected results into `result`, then go to DONE.
  - Quotient is negated when the dividend and divisor signs differ (signed mode only).
  - Remainder is negated when the dividend is negative (signed mode only).
  - Remainder magnitude is always less than the divisor magnitude, and `quotient*divisor + remainder == dividend` holds mod 2^WIDTH.
- **Overflow case**: signed most-negative / −1 gives quotient = most-negative (wraps) and remainder = 0, `div_zero` = 0. It needs no special-case logic.
- **DONE**
  - `ready` = 1; `result` and `div_zero` are held stable.
  - `start` low: go to IDLE. `start` still high: stay in DONE; there is no auto-restart.
  - A new operation needs `start` low for at least one cycle in IDLE.
- **Annul**: `annul` high in any state → IDLE on the next edge. `busy` and `ready` go low; `result` is held; any `start` on that edge is ignored.
- Operand inputs may change freely after the accepting edge without affecting the result.
- **Leaving DONE**: `result` and `div_zero` hold their values until the next accepting edge. The outputs are only meaningful while `ready` = 1.

## Timing
- **Reset**: while `resetn` is low, asynchronously force state = IDLE, counter = 0, `busy` = 0, `ready` = 0, `div_zero` = 0, `result` = 0 and all internal registers to 0. Release is synchronous to `clk`. Reset takes effect mid-operation with no residual state.
- **Normal latency**: edge E0 accepts `start`; `busy` is high from E0 to EW. `ready` rises after edge E(WIDTH), i.e. WIDTH+1 edges including E0, which is 33 for WIDTH = 32.
- **Divide-by-zero latency**: `ready` rises after E0 (1 edge); `busy` never asserts.
- `busy` and `ready` are never high at the same time; both are registered outputs.
- `result` changes only on the DONE-entry edge, or on reset.

## Test plan
- WIDTH=32, unsigned 100 / 7, `start` held → `ready` after 33 edges; `result` = {0x00000002, 0x0000000E}; `div_zero` = 0; `busy` high for exactly 32 cycles.
- WIDTH=32, signed −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001. Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Unsigned 0x12345678 / 0 → `ready` after 1 edge; `div_zero` = 1; `result` = {0x12345678, 0xFFFFFFFF}.
- Annul at iteration 10 with `start` still high → IDLE next edge, `ready` never rises. Then drop `start` one cycle, restart with 0xFFFFFFFF / 0x10 unsigned → quotient 0x0FFFFFFF, remainder 0xF.
- Deassert `resetn` asynchronously mid-BUSY (between edges) → `busy`/`ready`/`result` go to 0 immediately. After release, a fresh 9 / 3 gives quotient 3, remainder 0.
- WIDTH=8 instance: unsigned 200 / 3 → quotient 66, remainder 2, `ready` after 9 edges. Signed 0xC8 (−56) / 3 → quotient 0xEE (−18), remainder 0xFE (−2). `start` held high in DONE keeps `ready` = 1 with no restart.
